// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid bit, control bundle and payload with
// stall hold, flush-to-bubble and a saturating stall watchdog.
module pipe_stage_reg #(
    parameter int unsigned       CTRL_W      = 8,
    parameter int unsigned       DATA_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int unsigned       CNT_W       = 4,
    parameter int unsigned       STALL_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_en,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              stall_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_LIMIT);

    // The watchdog threshold must be reachable by the saturating counter.
    if (STALL_LIMIT == 0 || STALL_LIMIT > ((1 << CNT_W) - 1)) begin : g_bad_limit
        $error("pipe_stage_reg: STALL_LIMIT must be in 1 .. 2**CNT_W-1");
    end

    // Stage contents: flush beats stall beats load; data is left alone on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            ctrl_out  <= BUBBLE_CTRL;
            data_out  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
            ctrl_out  <= BUBBLE_CTRL;
        end else if (!stall_en) begin
            valid_out <= valid_in;
            ctrl_out  <= valid_in ? ctrl_in : BUBBLE_CTRL;
            data_out  <= data_in;
        end
    end

    // Counts edges on which a valid entry was held; empty-stage stalls never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (flush || !stall_en || !valid_out) begin
            stall_cnt <= '0;
        end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_timeout = (stall_cnt >= CNT_LIMIT);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, scoreboard queue and
// hand-written watchdog / async-reset sequences.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_en;
    logic        flush;
    logic        valid_in;
    logic [7:0]  ctrl_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [7:0]  ctrl_out;
    logic [15:0] data_out;
    logic [3:0]  stall_cnt;
    logic        stall_timeout;

    int tests = 0;
    int fails = 0;

    pipe_stage_reg #(
        .CTRL_W(8), .DATA_W(16), .BUBBLE_CTRL(8'h00), .CNT_W(4), .STALL_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst), .stall_en(stall_en), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(valid_out), .ctrl_out(ctrl_out), .data_out(data_out),
        .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        vin;
        logic [7:0]  cin;
        logic [15:0] din;
        logic        ev;
        logic [7:0]  ec;
        logic [15:0] ed;
        logic [3:0]  ecnt;
        logic        eto;
    } vec_t;

    typedef struct {
        string       name;
        logic        ev;
        logic [7:0]  ec;
        logic [15:0] ed;
        logic [3:0]  ecnt;
        logic        eto;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.name, ".valid"}, 32'(valid_out), 32'(e.ev));
        check({e.name, ".ctrl"},  32'(ctrl_out),  32'(e.ec));
        check({e.name, ".data"},  32'(data_out),  32'(e.ed));
        check({e.name, ".cnt"},   32'(stall_cnt), 32'(e.ecnt));
        check({e.name, ".to"},    32'(stall_timeout), 32'(e.eto));
        if (!valid_out && ctrl_out !== 8'h00) begin
            tests++;
            fails++;
            $display("FAIL %s.invariant: ctrl 0x%0h with valid_out=0, expected 0x0", e.name, ctrl_out);
        end
    endtask

    // Drive one edge's inputs, queue the expectation, compare after the edge.
    task automatic step(input string name, input logic s, input logic f, input logic v,
                        input logic [7:0] c, input logic [15:0] d,
                        input logic ev, input logic [7:0] ec, input logic [15:0] ed,
                        input logic [3:0] ecnt, input logic eto);
        exp_t e;
        stall_en = s; flush = f; valid_in = v; ctrl_in = c; data_in = d;
        e.name = name; e.ev = ev; e.ec = ec; e.ed = ed; e.ecnt = ecnt; e.eto = eto;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty, expected 1 entry", name);
        end else begin
            check_all(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic ev, input logic [7:0] ec,
                             input logic [15:0] ed, input logic [3:0] ecnt, input logic eto);
        exp_t e;
        e.name = name; e.ev = ev; e.ec = ec; e.ed = ed; e.ecnt = ecnt; e.eto = eto;
        check_all(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        stall flush vin cin    din       ev  ec     ed        cnt  to
        vecs[0]  = '{0, 0, 1, 8'hA5, 16'h1234, 1, 8'hA5, 16'h1234, 4'd0, 0};
        vecs[1]  = '{0, 0, 1, 8'h3C, 16'hBEEF, 1, 8'h3C, 16'hBEEF, 4'd0, 0};
        vecs[2]  = '{1, 0, 1, 8'hFF, 16'h0000, 1, 8'h3C, 16'hBEEF, 4'd1, 0};
        vecs[3]  = '{1, 0, 1, 8'hFF, 16'h0000, 1, 8'h3C, 16'hBEEF, 4'd2, 0};
        vecs[4]  = '{1, 0, 1, 8'hFF, 16'h0000, 1, 8'h3C, 16'hBEEF, 4'd3, 0};
        vecs[5]  = '{1, 1, 1, 8'hFF, 16'h0000, 0, 8'h00, 16'hBEEF, 4'd0, 0};
        vecs[6]  = '{0, 0, 0, 8'hFF, 16'h5555, 0, 8'h00, 16'h5555, 4'd0, 0};
        vecs[7]  = '{1, 0, 1, 8'h77, 16'hAAAA, 0, 8'h00, 16'h5555, 4'd0, 0};
        vecs[8]  = '{0, 1, 1, 8'h77, 16'hAAAA, 0, 8'h00, 16'h5555, 4'd0, 0};
        vecs[9]  = '{0, 0, 1, 8'h12, 16'h0042, 1, 8'h12, 16'h0042, 4'd0, 0};
        vecs[10] = '{0, 1, 1, 8'h34, 16'h9999, 0, 8'h00, 16'h0042, 4'd0, 0};
        vecs[11] = '{0, 0, 1, 8'h00, 16'hFFFF, 1, 8'h00, 16'hFFFF, 4'd0, 0};
        vecs[12] = '{1, 0, 0, 8'h9A, 16'h1111, 1, 8'h00, 16'hFFFF, 4'd1, 0};
        vecs[13] = '{0, 0, 0, 8'h9A, 16'h1111, 0, 8'h00, 16'h1111, 4'd0, 0};

        rst = 1'b1; stall_en = 0; flush = 0; valid_in = 0; ctrl_in = '0; data_in = '0;
        #2;
        check_now("reset_state", 0, 8'h00, 16'h0000, 4'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load something, then reset mid-cycle: outputs clear without an edge.
        step("pre_reset_load", 0, 0, 1, 8'hC3, 16'h7777, 1, 8'hC3, 16'h7777, 4'd0, 0);
        rst = 1'b1;
        #1;
        check_now("async_reset", 0, 8'h00, 16'h0000, 4'd0, 0);
        #1;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].vin,
                 vecs[i].cin, vecs[i].din, vecs[i].ev, vecs[i].ec, vecs[i].ed,
                 vecs[i].ecnt, vecs[i].eto);
        end

        // Stalling an empty stage never counts.
        for (int i = 0; i < 10; i++)
            step($sformatf("empty_stall%0d", i), 1, 0, 1, 8'hEE, 16'h2222,
                 0, 8'h00, 16'h1111, 4'd0, 0);

        // Watchdog: valid entry held for 20 edges.
        step("wd_load", 0, 0, 1, 8'h5A, 16'hCAFE, 1, 8'h5A, 16'hCAFE, 4'd0, 0);
        for (int k = 1; k <= 20; k++)
            step($sformatf("wd_edge%0d", k), 1, 0, 1, 8'h11, 16'h3333,
                 1, 8'h5A, 16'hCAFE, 4'((k > 15) ? 15 : k), (k >= 8));
        step("wd_release", 0, 0, 1, 8'h66, 16'h4444, 1, 8'h66, 16'h4444, 4'd0, 0);

        // Async reset in the middle of a long stall.
        for (int k = 1; k <= 12; k++)
            step($sformatf("rs_edge%0d", k), 1, 0, 0, 8'h00, 16'h0000,
                 1, 8'h66, 16'h4444, 4'(k), (k >= 8));
        rst = 1'b1;
        #1;
        check_now("reset_mid_stall", 0, 8'h00, 16'h0000, 4'd0, 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        step("post_reset_load", 0, 0, 1, 8'hA5, 16'h1234, 1, 8'hA5, 16'h1234, 4'd0, 0);

        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
